piso_shift_register: RTL and testbench

- Parallel-in serial-out shift register.
- Captures a WIDTH-bit parallel word and emits it LSB-first on a single serial output, one bit per clock.
- Reloads automatically every WIDTH cycles, so a static input word streams out continuously.
- Used as a serialiser between a parallel data source and a 1-bit link.

---
 rtl/piso_shift_register.sv | 50 +++++
 tb/tb_piso_shift_register.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/piso_shift_register.sv
// Purpose: parallel-in serial-out shifter, frames WIDTH bits LSB-first onto OUT, reloading every WIDTH clocks.
// Latency: IN[0] is on OUT right after the first rising edge out of reset; IN[k] follows k edges later.
// Backpressure: none; the serial stream is free-running and IN is sampled only on load edges.
module piso_shift_register #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] IN,
    input  logic             CLK,
    input  logic             RESET,
    output logic             OUT
);

    // Counter spans 0..WIDTH-1; zero marks a load edge.
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic             w_load;
    logic [CW-1:0]    w_cnt_nxt;

    assign w_load = (r_cnt == '0);

    // Explicit wrap so non-power-of-two widths still give a WIDTH-edge frame.
    always_comb begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
        end
    end

    // Load on count zero, otherwise shift right with zero fill; reset clears immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_sh  <= IN;
            r_cnt <= CNT_ONE;
        end else begin
            r_sh  <= {1'b0, r_sh[WIDTH-1:1]};
            r_cnt <= w_cnt_nxt;
        end
    end

    // Serial output always comes from the register, never straight from IN.
    assign OUT = r_sh[0];

endmodule

// File: tb/tb_piso_shift_register.sv
// Purpose: directed table-driven bench for piso_shift_register at WIDTH=4 and WIDTH=8.
// Latency: inputs driven on the falling edge, OUT sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus runs on a fixed clock schedule.
module tb_piso_shift_register;

    typedef struct {
        logic       rst;
        logic [3:0] in;
        logic       exp_out;
    } vec_t;

    logic       clk;
    logic       rst4;
    logic [3:0] in4;
    logic       out4;
    logic       rst8;
    logic [7:0] in8;
    logic       out8;

    int applied;
    int miscompares;

    vec_t vecs[$];

    piso_shift_register #(.WIDTH(4)) dut4 (
        .IN    (in4),
        .CLK   (clk),
        .RESET (rst4),
        .OUT   (out4)
    );

    piso_shift_register #(.WIDTH(8)) dut8 (
        .IN    (in8),
        .CLK   (clk),
        .RESET (rst8),
        .OUT   (out8)
    );

    // Period 4, rising edges at 2, 6, 10, ...
    initial clk = 1'b0;
    always #2 clk = ~clk;

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %b, expected %b at t=%0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic check_cnt(input string name, input int idx, input int act, input int exp);
        applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %0d, expected %0d at t=%0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic step4(input string name, input int idx, input logic rst, input logic [3:0] in,
                         input logic exp);
        @(negedge clk);
        rst4 = rst;
        in4  = in;
        @(posedge clk);
        #1;
        check(name, idx, out4, exp);
        if (rst) check_cnt({name, "_cnt"}, idx, int'(dut4.r_cnt), 0);
    endtask

    task automatic add(input logic rst, input logic [3:0] in, input logic exp);
        vec_t v;
        v.rst = rst; v.in = in; v.exp_out = exp;
        vecs.push_back(v);
    endtask

    logic [7:0] word8;

    initial begin
        applied     = 0;
        miscompares = 0;
        rst4 = 1'b1;
        in4  = 4'b1101;
        rst8 = 1'b1;
        in8  = 8'hA5;

        // Reset state before any clock edge.
        #1;
        check("reset_out4", 0, out4, 1'b0);
        check("reset_out8", 0, out8, 1'b0);

        // Basic frame 1101 -> 1,0,1,1 then reload, then second frame.
        add(0, 4'b1101, 1); add(0, 4'b1101, 0); add(0, 4'b1101, 1); add(0, 4'b1101, 1);
        add(0, 4'b1101, 1); add(0, 4'b1101, 0); add(0, 4'b1101, 1); add(0, 4'b1101, 1);
        // Continuous streaming of 0110 for three frames.
        for (int f = 0; f < 3; f++) begin
            add(0, 4'b0110, 0); add(0, 4'b0110, 1); add(0, 4'b0110, 1); add(0, 4'b0110, 0);
        end
        // IN changes after the second edge; frame in progress is unaffected.
        add(0, 4'b1111, 1); add(0, 4'b1111, 1); add(0, 4'b0000, 1); add(0, 4'b0000, 1);
        add(0, 4'b0000, 0); add(0, 4'b0000, 0); add(0, 4'b0000, 0); add(0, 4'b0000, 0);
        // Reset held across five edges with IN toggling.
        add(1, 4'b1010, 0); add(1, 4'b0101, 0); add(1, 4'b1111, 0); add(1, 4'b0000, 0);
        add(1, 4'b1011, 0);
        // First edge after release loads.
        add(0, 4'b1011, 1); add(0, 4'b1011, 1); add(0, 4'b1011, 0); add(0, 4'b1011, 1);
        // Start a frame to be aborted.
        add(0, 4'b0111, 1); add(0, 4'b0111, 1); add(0, 4'b0111, 1);

        foreach (vecs[i]) begin
            step4("vec", i, vecs[i].rst, vecs[i].in, vecs[i].exp_out);
        end

        // Async reset during bit 2 (OUT=1): assert between edges, no rising edge before the check.
        rst4 = 1'b1;
        in4  = 4'b1001;
        @(negedge clk);
        check("async_rst_out", 0, out4, 1'b0);
        check_cnt("async_rst_cnt", 0, int'(dut4.r_cnt), 0);
        rst4 = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst", 0, out4, 1'b1);
        step4("post_rst", 1, 0, 4'b1001, 0);
        step4("post_rst", 2, 0, 4'b1001, 0);
        step4("post_rst", 3, 0, 4'b1001, 1);
        step4("post_rst", 4, 0, 4'b0010, 0);

        // WIDTH=8: A5 streams LSB-first, IN changed mid-frame only takes effect on reload.
        @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        check("w8_reset", 0, out8, 1'b0);
        rst8  = 1'b0;
        word8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("w8_a5", i, out8, word8[i]);
            if (i == 3) in8 = 8'h3C;
            @(negedge clk);
        end
        word8 = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("w8_3c", i, out8, word8[i]);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
